// File: rtl/tetromino_bag_sequencer.sv
// -----------------------------------------------------------------------------
// tetromino_bag_sequencer
//
// Turns a free-running random word into the game's piece stream under a 7-bag
// policy: every bag of seven consecutive pieces holds each tetromino exactly
// once. Drawn pieces enter an in-order queue of depth preview_p+1 whose head
// and preview slots are presented to the game-control FSM. A draw that keeps
// missing falls back to the lowest remaining piece after 8 cycles.
//
// Ports
//   clk_i        rising-edge clock
//   reset_i      asynchronous, active-high reset
//   random_i     random word, only bits [2:0] are consumed
//   take_i       pop the head piece this cycle (ignored when v_o=0)
//   piece_o      head piece code: 0=I 1=O 2=T 3=S 4=Z 5=J 6=L
//   v_o          head piece valid
//   preview_o    slot i+1 at bits [3*i+2:3*i]; invalid slots read 0
//   preview_v_o  bit i = preview slot i+1 valid
//   bag_count_o  pieces still available in the current bag (1..7)
// -----------------------------------------------------------------------------
module tetromino_bag_sequencer #(
    parameter int width_p   = 32,
    parameter int preview_p = 3
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [width_p-1:0]       random_i,
    input  logic                     take_i,
    output logic [2:0]               piece_o,
    output logic                     v_o,
    output logic [3*preview_p-1:0]   preview_o,
    output logic [preview_p-1:0]     preview_v_o,
    output logic [2:0]               bag_count_o
);

    localparam int q_lp = preview_p + 1;

    // Queue slot 0 is the head. vld_r is a thermometer code (valid slots are
    // always contiguous from the head), and invalid slots always hold 0 so the
    // outputs need no masking.
    logic [2:0]      q_r     [q_lp];
    logic [2:0]      q_n     [q_lp];
    logic [2:0]      q_shift [q_lp];
    logic [q_lp-1:0] vld_r, vld_n, vld_shift, vld_new;
    logic [6:0]      mask_r, mask_n, mask_clr;
    logic [2:0]      retry_r, retry_n;
    logic [2:0]      bag_count_r, bag_count_n;

    logic       pop, draw_en, hit, accept;
    logic [2:0] cand, lowest, pick;
    logic [7:0] mask_ext;

    // Upper random bits are intentionally not consumed.
    generate
        if (width_p > 3) begin : g_unused
            logic unused_random;
            assign unused_random = ^random_i[width_p-1:3];
        end
    endgenerate

    always_comb begin
        // NOTE: every combinational output gets a default before any branch so
        // no path leaves it unassigned and no latch is inferred.
        pop      = take_i & vld_r[0];
        cand     = random_i[2:0];
        mask_ext = {1'b0, mask_r};   // candidate 7 indexes the always-zero bit
        hit      = mask_ext[cand];

        // Shift toward the head first; a same-cycle draw then writes into the
        // first free slot of the shifted queue.
        for (int i = 0; i < q_lp - 1; i++) begin
            q_shift[i] = pop ? q_r[i+1] : q_r[i];
        end
        q_shift[q_lp-1] = pop ? 3'd0 : q_r[q_lp-1];
        vld_shift       = pop ? (vld_r >> 1) : vld_r;

        draw_en = ~vld_shift[q_lp-1];

        // Fallback choice: lowest piece still in the bag (mask is never 0).
        lowest = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (mask_r[i]) lowest = 3'(i);
        end

        accept = draw_en & (hit | (retry_r == 3'd7));
        pick   = hit ? cand : lowest;

        q_n         = q_shift;
        vld_n       = vld_shift;
        vld_new     = '0;
        mask_n      = mask_r;
        mask_clr    = mask_r & ~(7'd1 << pick);
        retry_n     = retry_r;

        if (accept) begin
            vld_n   = {vld_shift[q_lp-2:0], 1'b1};
            vld_new = vld_n & ~vld_shift;   // the single slot being filled
            for (int i = 0; i < q_lp; i++) begin
                if (vld_new[i]) q_n[i] = pick;
            end
            // An emptied bag is refilled on the same edge.
            mask_n  = (mask_clr == 7'd0) ? 7'h7F : mask_clr;
            retry_n = 3'd0;
        end else if (draw_en) begin
            retry_n = retry_r + 3'd1;
        end

        bag_count_n = 3'd0;
        for (int i = 0; i < 7; i++) begin
            bag_count_n = bag_count_n + {2'b00, mask_n[i]};
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            // NOTE: the queue storage is reset too, because invalid slots are
            // visible on the outputs and must read 0.
            for (int i = 0; i < q_lp; i++) q_r[i] <= 3'd0;
            vld_r       <= '0;
            mask_r      <= 7'h7F;
            retry_r     <= 3'd0;
            bag_count_r <= 3'd7;
        end else begin
            // NOTE: state registers use non-blocking assignment so every
            // register samples pre-edge values regardless of statement order.
            for (int i = 0; i < q_lp; i++) q_r[i] <= q_n[i];
            vld_r       <= vld_n;
            mask_r      <= mask_n;
            retry_r     <= retry_n;
            bag_count_r <= bag_count_n;
        end
    end

    assign piece_o     = q_r[0];
    assign v_o         = vld_r[0];
    assign preview_v_o = vld_r[q_lp-1:1];
    assign bag_count_o = bag_count_r;

    generate
        for (genvar g = 0; g < preview_p; g++) begin : g_preview
            assign preview_o[3*g +: 3] = q_r[g+1];
        end
    endgenerate

endmodule
